// File: rtl/unidade_sequenciadora_pkg.sv
// caminho_pkg: encodings shared by the instruction sequencer and its helpers.
//   - state codes (4 bits, also the value presented on estado)
//   - instruction class codes (opcode[6:4])
//   - branch funct3 codes
//   - tipo_legal(): true for the instruction classes the datapath supports
package caminho_pkg;

   localparam logic [3:0] ST_IDLE     = 4'b0000;
   localparam logic [3:0] ST_FETCH    = 4'b0001;
   localparam logic [3:0] ST_DECODE   = 4'b0010;
   localparam logic [3:0] ST_EXEC     = 4'b0011;
   localparam logic [3:0] ST_MEM_WAIT = 4'b0100;
   localparam logic [3:0] ST_HALT     = 4'b1110;
   localparam logic [3:0] ST_COMMIT   = 4'b1111;

   localparam logic [2:0] LW     = 3'b000;
   localparam logic [2:0] ADDI   = 3'b001;
   localparam logic [2:0] SW     = 3'b010;
   localparam logic [2:0] RTYPE  = 3'b011;
   localparam logic [2:0] BRANCH = 3'b110;

   localparam logic [2:0] BEQ = 3'b000;
   localparam logic [2:0] BNE = 3'b001;

   function automatic logic tipo_legal(input logic [2:0] t);
      return (t == LW) || (t == ADDI) || (t == SW) || (t == RTYPE) || (t == BRANCH);
   endfunction

endpackage

// File: rtl/unidade_sequenciadora_avaliador_desvio.sv
// avaliador_desvio: combinational branch resolution.
//   tipo   [2:0] in  instruction class
//   funct3 [2:0] in  branch condition select
//   zero         in  ALU zero flag
//   taken        out branch redirects the PC (BEQ with zero, BNE without)
module avaliador_desvio
   import caminho_pkg::*;
(
   input  logic [2:0] tipo,
   input  logic [2:0] funct3,
   input  logic       zero,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      if (tipo == BRANCH) begin
         case (funct3)
            BEQ:     taken = zero;
            BNE:     taken = ~zero;
            default: taken = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/unidade_sequenciadora.sv
// unidade_sequenciadora: multi-cycle instruction sequencer.
//   clk, reset         clock, synchronous active-high reset
//   start, stop        leave IDLE / return to IDLE after the current COMMIT
//   tipo, funct3, zero instruction class, funct3, ALU zero flag
//   mem_ready          memory finishes the pending access this cycle
//   estado [3:0]       state register, drives the control-signal generator
//   mem_req, ir_write, pc_write, pc_src, instr_done, halted  control outputs
// Build option: define ILLEGAL_TRAP_EN to trap illegal instruction classes in
// HALT (left only by reset); otherwise they retire as a NOP.
//
// state    | meaning
// IDLE     | waiting for start, all outputs low
// FETCH    | instruction read, IR loaded when mem_ready
// DECODE   | classify tipo
// EXEC     | ALU cycle; loads/stores go on to MEM_WAIT
// MEM_WAIT | data access pending until mem_ready
// COMMIT   | update PC, retire instruction, check stop
// HALT     | illegal-instruction trap (ILLEGAL_TRAP_EN only)
module unidade_sequenciadora
   import caminho_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic [2:0] tipo,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [3:0] estado,
   output logic       mem_req,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       instr_done,
   output logic       halted
);

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic       taken;

   avaliador_desvio u_avaliador_desvio (
      .tipo   (tipo),
      .funct3 (funct3),
      .zero   (zero),
      .taken  (taken)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (start) state_d = ST_FETCH;
         ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            if (tipo_legal(tipo)) begin
               state_d = ST_EXEC;
            end else begin
`ifdef ILLEGAL_TRAP_EN
               state_d = ST_HALT;
`else
               state_d = ST_COMMIT;
`endif
            end
         end
         ST_EXEC:     state_d = ((tipo == LW) || (tipo == SW)) ? ST_MEM_WAIT : ST_COMMIT;
         ST_MEM_WAIT: if (mem_ready) state_d = ST_COMMIT;
         ST_COMMIT:   state_d = stop ? ST_IDLE : ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
         ST_HALT:     state_d = ST_HALT;
`endif
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Outputs are forced low while reset is asserted, so a reset raised in the
   // middle of an access drops mem_req without waiting for the state change.
   assign estado     = state_q;
   assign mem_req    = ~reset & ((state_q == ST_FETCH) || (state_q == ST_MEM_WAIT));
   assign ir_write   = ~reset & (state_q == ST_FETCH) & mem_ready;
   assign pc_write   = ~reset & (state_q == ST_COMMIT);
   assign instr_done = ~reset & (state_q == ST_COMMIT);
   assign pc_src     = ~reset & (state_q == ST_COMMIT) & taken;
`ifdef ILLEGAL_TRAP_EN
   assign halted     = ~reset & (state_q == ST_HALT);
`else
   assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_sequenciadora.sv
module tb_unidade_sequenciadora;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic [2:0] tipo;
   logic [2:0] funct3;
   logic       zero;
   logic       mem_ready;
   logic [3:0] estado;
   logic       mem_req;
   logic       ir_write;
   logic       pc_write;
   logic       pc_src;
   logic       instr_done;
   logic       halted;

   int n_tests = 0;
   int n_fail  = 0;

   unidade_sequenciadora dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .tipo       (tipo),
      .funct3     (funct3),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .estado     (estado),
      .mem_req    (mem_req),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .instr_done (instr_done),
      .halted     (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Leaves the bench at a falling edge with the DUT in IDLE and reset low.
   task automatic apply_reset;
      reset = 1'b1; start = 1'b0; stop = 1'b0; mem_ready = 1'b0;
      tipo = 3'b000; funct3 = 3'b000; zero = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b1; stop = 1'b0; mem_ready = 1'b1;
      tipo = 3'b001; funct3 = 3'b000; zero = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      n_tests++;
      if (estado !== 4'b0000 || {mem_req, ir_write, pc_write, pc_src, instr_done, halted} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_hold: estado=%b outs=%b, expected 0000 / 000000", estado,
                  {mem_req, ir_write, pc_write, pc_src, instr_done, halted});
      end
      reset = 1'b0;
      @(negedge clk); #1;
      n_tests++;
      if (estado !== 4'b0001 || {pc_write, pc_src, instr_done, halted} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_release: estado=%b, expected 0001 after first start cycle", estado);
      end
      apply_reset();
      @(negedge clk); #1;
      n_tests++;
      if (estado !== 4'b0000 || {mem_req, ir_write, pc_write, pc_src, instr_done, halted} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_after: estado=%b outs=%b, expected 0000 / 000000", estado,
                  {mem_req, ir_write, pc_write, pc_src, instr_done, halted});
      end
   endtask

   task automatic test_addi;
      logic [3:0] exp_st [0:4];
      logic [3:0] exp_outs;
      exp_st[0] = 4'b0001; exp_st[1] = 4'b0010; exp_st[2] = 4'b0011;
      exp_st[3] = 4'b1111; exp_st[4] = 4'b0001;
      apply_reset();
      start = 1'b1; tipo = 3'b001; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         // {mem_req, ir_write, pc_write, instr_done}
         exp_outs = (exp_st[i] == 4'b0001) ? 4'b1100 :
                    (exp_st[i] == 4'b1111) ? 4'b0011 : 4'b0000;
         n_tests++;
         if (estado !== exp_st[i] || {mem_req, ir_write, pc_write, instr_done} !== exp_outs) begin
            n_fail++;
            $display("FAIL addi_step%0d: estado=%b outs=%b, expected %b / %b", i, estado,
                     {mem_req, ir_write, pc_write, instr_done}, exp_st[i], exp_outs);
         end
      end
   endtask

   task automatic test_lw_wait;
      apply_reset();
      start = 1'b1; tipo = 3'b000; mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_tests++;
         if (estado !== 4'b0001 || mem_req !== 1'b1 || ir_write !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait%0d: estado=%b mem_req=%b ir_write=%b, expected 0001 1 0",
                     i, estado, mem_req, ir_write);
         end
      end
      mem_ready = 1'b1; #1;
      n_tests++;
      if (ir_write !== 1'b1) begin
         n_fail++;
         $display("FAIL fetch_ir_write: ir_write=%b, expected 1", ir_write);
      end
      @(negedge clk);
      @(negedge clk); #1;
      mem_ready = 1'b0;
      n_tests++;
      if (estado !== 4'b0011) begin
         n_fail++;
         $display("FAIL lw_exec: estado=%b, expected 0011", estado);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (i == 3) mem_ready = 1'b1;
         #1;
         n_tests++;
         if (estado !== 4'b0100 || mem_req !== 1'b1 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_mem_wait%0d: estado=%b mem_req=%b ir_write=%b pc_write=%b, expected 0100 1 0 0",
                     i, estado, mem_req, ir_write, pc_write);
         end
      end
      @(negedge clk); #1;
      stop = 1'b1; start = 1'b0;
      n_tests++;
      if (estado !== 4'b1111 || instr_done !== 1'b1 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL lw_commit: estado=%b instr_done=%b mem_req=%b, expected 1111 1 0",
                  estado, instr_done, mem_req);
      end
      @(negedge clk); #1;
      n_tests++;
      if (estado !== 4'b0000) begin
         n_fail++;
         $display("FAIL stop_to_idle: estado=%b, expected 0000", estado);
      end
   endtask

   task automatic test_branch;
      // {tipo, funct3, zero, expected pc_src}
      logic [7:0] vec [0:6];
      vec[0] = {3'b110, 3'b001, 1'b0, 1'b1};
      vec[1] = {3'b110, 3'b001, 1'b1, 1'b0};
      vec[2] = {3'b110, 3'b000, 1'b1, 1'b1};
      vec[3] = {3'b110, 3'b000, 1'b0, 1'b0};
      vec[4] = {3'b011, 3'b001, 1'b0, 1'b0};
      vec[5] = {3'b110, 3'b010, 1'b1, 1'b0};
      vec[6] = {3'b001, 3'b000, 1'b1, 1'b0};
      apply_reset();
      start = 1'b1; stop = 1'b1; mem_ready = 1'b1;
      for (int v = 0; v < 7; v++) begin
         tipo = vec[v][7:5]; funct3 = vec[v][4:2]; zero = vec[v][1];
         for (int c = 0; c < 4; c++) @(negedge clk);
         #1;
         n_tests++;
         if (estado !== 4'b1111 || pc_write !== 1'b1 || pc_src !== vec[v][0]) begin
            n_fail++;
            $display("FAIL branch_vec%0d: estado=%b pc_write=%b pc_src=%b, expected 1111 1 %b",
                     v, estado, pc_write, pc_src, vec[v][0]);
         end
         @(negedge clk); #1;
         n_tests++;
         if (estado !== 4'b0000 || pc_src !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_idle%0d: estado=%b pc_src=%b, expected 0000 0", v, estado, pc_src);
         end
      end
   endtask

   task automatic test_illegal;
      apply_reset();
      start = 1'b1; tipo = 3'b111; mem_ready = 1'b1; funct3 = 3'b001; zero = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      n_tests++;
      if (estado !== 4'b0010) begin
         n_fail++;
         $display("FAIL illegal_decode: estado=%b, expected 0010", estado);
      end
`ifdef ILLEGAL_TRAP_EN
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         n_tests++;
         if (estado !== 4'b1110 || halted !== 1'b1 ||
             {mem_req, ir_write, pc_write, pc_src, instr_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL halt_hold%0d: estado=%b halted=%b outs=%b, expected 1110 1 00000", i,
                     estado, halted, {mem_req, ir_write, pc_write, pc_src, instr_done});
         end
      end
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      n_tests++;
      if (estado !== 4'b0000 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_reset: estado=%b halted=%b, expected 0000 0", estado, halted);
      end
`else
      @(negedge clk); #1;
      n_tests++;
      if (estado !== 4'b1111 || pc_write !== 1'b1 || pc_src !== 1'b0 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_nop: estado=%b pc_write=%b pc_src=%b halted=%b, expected 1111 1 0 0",
                  estado, pc_write, pc_src, halted);
      end
      @(negedge clk); #1;
      n_tests++;
      if (estado !== 4'b0001 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_next: estado=%b halted=%b, expected 0001 0", estado, halted);
      end
`endif
   endtask

   task automatic test_reset_mid;
      apply_reset();
      start = 1'b1; tipo = 3'b001; mem_ready = 1'b0;
      @(negedge clk); #1;
      n_tests++;
      if (estado !== 4'b0001 || mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_fetch: estado=%b mem_req=%b, expected 0001 1", estado, mem_req);
      end
      reset = 1'b1;
      @(negedge clk); #1;
      n_tests++;
      if (estado !== 4'b0000 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_fetch: estado=%b mem_req=%b, expected 0000 0", estado, mem_req);
      end
      reset = 1'b0; tipo = 3'b010; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) @(negedge clk);
      #1;
      mem_ready = 1'b0;
      n_tests++;
      if (estado !== 4'b0100) begin
         n_fail++;
         $display("FAIL sw_mem_wait: estado=%b, expected 0100", estado);
      end
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0; start = 1'b0;
      n_tests++;
      if (estado !== 4'b0000 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_mem_wait: estado=%b mem_req=%b, expected 0000 0", estado, mem_req);
      end
   endtask

   task automatic test_back_to_back;
      int pulses;
      pulses = 0;
      apply_reset();
      start = 1'b1; stop = 1'b0; tipo = 3'b011; mem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         if (instr_done === 1'b1) pulses++;
      end
      n_tests++;
      if (pulses != 2 || estado !== 4'b1111) begin
         n_fail++;
         $display("FAIL back_to_back: pulses=%0d estado=%b, expected 2 1111", pulses, estado);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; mem_ready = 1'b0;
      tipo = 3'b000; funct3 = 3'b000; zero = 1'b0;
      test_reset();
      test_addi();
      test_lw_wait();
      test_branch();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/unidade_sequenciadora.md
UNIDADE_SEQUENCIADORA -- requirements
Module: unidade_sequenciadora

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  level; leaves IDLE.
REQ-005 stop  input  1  level; sampled only in COMMIT; return to IDLE after current instruction.
REQ-006 tipo  input  3  opcode[6:4] of the instruction register.
REQ-007 funct3  input  3  instruction funct3.
REQ-008 zero  input  1  ALU zero flag.
REQ-009 mem_ready  input  1  memory completes current access this cycle.
REQ-010 estado  output  4  current state code, drives the control-signal generator.
REQ-011 mem_req  output  1  memory access request.
REQ-012 ir_write  output  1  load instruction register.
REQ-013 pc_write  output  1  update PC.
REQ-014 pc_src  output  1  0 = PC+4, 1 = branch target; meaningful only with pc_write.
REQ-015 instr_done  output  1  one-cycle pulse per retired instruction.
REQ-016 halted  output  1  high while in HALT.

Function
REQ-017 State codes: IDLE 0000, FETCH 0001, DECODE 0010, EXEC 0011, MEM_WAIT 0100, HALT 1110, COMMIT 1111; estado equals the state register, and no other codes ever appear.
REQ-018 Legal tipo values: 000 lw, 001 addi, 010 sw, 011 R-type, 110 branch; all others are illegal.
REQ-019 IDLE: start=1 -> FETCH; otherwise stay; all outputs 0.
REQ-020 FETCH: mem_req=1; mem_ready=1 -> ir_write=1 in that same cycle, next DECODE; mem_ready=0 -> stay (unbounded wait).
REQ-021 DECODE: one cycle; legal tipo -> EXEC; illegal tipo -> see REQ-031/032.
REQ-022 EXEC: one cycle; lw/sw -> MEM_WAIT; other legal types -> COMMIT.
REQ-023 MEM_WAIT: mem_req=1; mem_ready=1 -> COMMIT; else stay.
REQ-024 COMMIT: one cycle; pc_write=1 and instr_done=1; stop=1 -> IDLE, else -> FETCH.
REQ-025 Branch rule in COMMIT:
- pc_src=1 only if tipo=110 and either funct3=000 with zero=1, or funct3=001 with zero=0.
- Otherwise pc_src=0.
REQ-026 mem_ready is ignored outside FETCH/MEM_WAIT.
REQ-027 Latency with mem_ready tied high:
- addi/R/branch = 4 cycles FETCH->COMMIT.
- lw/sw = 5 cycles.
REQ-028 Outputs are decoded from state; ir_write and pc_src additionally depend on current inputs; no output glitches across states within a cycle.

Reset
REQ-029 reset=1 -> next state IDLE, overriding every transition including mid-FETCH/MEM_WAIT and HALT.
REQ-030 While in reset and the cycle after: estado=0000 and all other outputs 0.

Configuration
REQ-031 ILLEGAL_TRAP_EN defined: illegal tipo in DECODE -> HALT; in HALT, halted=1 and all other outputs 0; HALT is left only via reset.
REQ-032 ILLEGAL_TRAP_EN undefined: illegal tipo in DECODE -> COMMIT (treated as NOP, pc_src=0); HALT unreachable and halted tied 0.

Structure
REQ-033 Package caminho_pkg holds: state encoding constants, tipo constants (LW, ADDI, SW, RTYPE, BRANCH), and branch funct3 constants (BEQ, BNE).
REQ-034 Sub-module avaliador_desvio (tipo, funct3, zero -> taken) is combinational and instantiated once for pc_src.

Verification
REQ-035 Reset, then start=1, tipo=001, mem_ready=1 -> estado 0001,0010,0011,1111,0001; instr_done high only in the 1111 cycle.
REQ-036 tipo=000, mem_ready low 3 cycles in MEM_WAIT -> estado 0100 held 4 cycles, mem_req=1 throughout, then 1111.
REQ-037 tipo=110, funct3=001, zero=0 -> pc_src=1 with pc_write=1 in COMMIT; repeat with zero=1 -> pc_src=0.
REQ-038 tipo=111 -> with ILLEGAL_TRAP_EN: estado 1110 and halted=1, persisting 10 cycles; without: 1111 then 0001 and pc_src=0.
REQ-039 reset asserted in FETCH while mem_req=1 -> next cycle estado=0000 and mem_req=0; stop=1 at COMMIT -> next estado 0000.
